// File: rtl/dual_psum_accumulator.sv
// dual_psum_accumulator: windowed saturating accumulation of dual int16 products
// into a 2-entry valid/ready output FIFO.
module dual_psum_accumulator #(
    parameter int ACC_W      = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_W-1:0]        len,
    input  logic signed [15:0]      mult_data1,
    input  logic signed [15:0]      mult_data2,
    input  logic                    mult_dv,
    output logic signed [ACC_W-1:0] acc1,
    output logic signed [ACC_W-1:0] acc2,
    output logic                    sat,
    output logic                    vld,
    input  logic                    rdy,
    output logic                    ovf,
    output logic                    busy
);
    typedef enum logic {IDLE, ACC} state_t;
    typedef struct packed {
        logic                    s;
        logic signed [ACC_W-1:0] a2;
        logic signed [ACC_W-1:0] a1;
    } entry_t;

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] sum1, sum2, nx1, nx2;
    logic signed [ACC_W:0]   add1, add2;
    logic [LEN_W-1:0]        cnt, win_len;
    logic                    win_sat, ov1, ov2, step, last, pop, clr, go;
    logic [1:0]              fill, fill_after;
    entry_t                  e0, e1, din;

    always_comb begin
        go         = state == IDLE && start && !abort;
        state_nx   = abort ? IDLE : go ? ACC : state;
        step       = state == ACC && !abort && mult_dv;
        last       = step && cnt == win_len - LEN_W'(1);
        clr        = go || (state == ACC && abort) || last;
        add1       = {sum1[ACC_W-1], sum1} + (ACC_W+1)'(mult_data1);
        add2       = {sum2[ACC_W-1], sum2} + (ACC_W+1)'(mult_data2);
        ov1        = add1[ACC_W] ^ add1[ACC_W-1];
        ov2        = add2[ACC_W] ^ add2[ACC_W-1];
        // on overflow the extra sign bit tells which rail to clamp to
        nx1        = ov1 ? {add1[ACC_W], {(ACC_W-1){~add1[ACC_W]}}} : add1[ACC_W-1:0];
        nx2        = ov2 ? {add2[ACC_W], {(ACC_W-1){~add2[ACC_W]}}} : add2[ACC_W-1:0];
        din        = '{s: win_sat | ov1 | ov2, a2: nx2, a1: nx1};
        pop        = vld && rdy;
        fill_after = fill - 2'(pop);
    end

    assign vld  = fill != 2'd0;
    assign acc1 = e0.a1;
    assign acc2 = e0.a2;
    assign sat  = e0.s;
    assign busy = state == ACC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum1    <= '0;
            sum2    <= '0;
            cnt     <= '0;
            win_len <= LEN_W'(1);
            win_sat <= 1'b0;
            ovf     <= 1'b0;
            fill    <= 2'd0;
            e0      <= '0;
            e1      <= '0;
        end else begin
            if (clr) begin
                sum1    <= '0;
                sum2    <= '0;
                cnt     <= '0;
                win_sat <= 1'b0;
            end else if (step) begin
                sum1    <= nx1;
                sum2    <= nx2;
                cnt     <= cnt + LEN_W'(1);
                win_sat <= win_sat | ov1 | ov2;
            end
            if (go) begin
                win_len <= len == '0 ? LEN_W'(1) : len;
                ovf     <= 1'b0;
            end
            // pop shifts first, so a push lands in the slot freed this cycle
            if (pop) e0 <= e1;
            if (last && fill_after == 2'd0) e0 <= din;
            if (last && fill_after == 2'd1) e1 <= din;
            if (last && fill_after == 2'(FIFO_DEPTH)) ovf <= 1'b1;
            fill <= fill_after + 2'(last && fill_after != 2'(FIFO_DEPTH));
        end
    end
endmodule

// File: tb/tb_dual_psum_accumulator.sv
// tb_dual_psum_accumulator: directed and random stimulus against a queue-based
// model, run on a 32-bit and a 17-bit accumulator instance in parallel.
module tb_dual_psum_accumulator;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, dv = 1'b0, rdy = 1'b0;
    logic [15:0] len = '0;
    logic signed [15:0] d1 = '0, d2 = '0;
    logic signed [31:0] a1_32, a2_32;
    logic signed [16:0] a1_17, a2_17;
    logic sat_32, vld_32, ovf_32, busy_32, sat_17, vld_17, ovf_17, busy_17;

    always #5 clk = ~clk;

    dual_psum_accumulator #(.ACC_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
        .mult_data1(d1), .mult_data2(d2), .mult_dv(dv),
        .acc1(a1_32), .acc2(a2_32), .sat(sat_32), .vld(vld_32), .rdy(rdy),
        .ovf(ovf_32), .busy(busy_32)
    );
    dual_psum_accumulator #(.ACC_W(17)) u17 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
        .mult_data1(d1), .mult_data2(d2), .mult_dv(dv),
        .acc1(a1_17), .acc2(a2_17), .sat(sat_17), .vld(vld_17), .rdy(rdy),
        .ovf(ovf_17), .busy(busy_17)
    );

    typedef struct {
        longint a1;
        longint a2;
        bit     s;
    } res_t;

    int     widths[2] = '{32, 17};
    res_t   q[2][$];
    bit     mbusy[2], movf[2], ms[2];
    longint s1[2], s2[2];
    int     mcnt[2], mlen[2];
    int     n_checks = 0, n_fail = 0;
    longint oa1[2], oa2[2];
    logic   osat[2], ovld[2], oovf[2], obusy[2];

    always_comb begin
        oa1[0] = longint'(a1_32); oa2[0] = longint'(a2_32);
        oa1[1] = longint'(a1_17); oa2[1] = longint'(a2_17);
        osat[0] = sat_32; ovld[0] = vld_32; oovf[0] = ovf_32; obusy[0] = busy_32;
        osat[1] = sat_17; ovld[1] = vld_17; oovf[1] = ovf_17; obusy[1] = busy_17;
    end

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat_add(longint a, longint b, int w, output bit o);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint v  = a + b;
        o = v > mx || v < -mx - 1;
        return v > mx ? mx : v < -mx - 1 ? -mx - 1 : v;
    endfunction

    // reference model: one window accumulator and a result queue per instance
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                q[k].delete();
                mbusy[k] = 0; movf[k] = 0; ms[k] = 0; s1[k] = 0; s2[k] = 0; mcnt[k] = 0;
            end else begin
                bit o1, o2;
                if (rdy && q[k].size() > 0) void'(q[k].pop_front());
                if (!mbusy[k]) begin
                    if (start && !abort) begin
                        mbusy[k] = 1; mlen[k] = len == 0 ? 1 : int'(len);
                        mcnt[k] = 0; s1[k] = 0; s2[k] = 0; ms[k] = 0; movf[k] = 0;
                    end
                end else if (abort) begin
                    mbusy[k] = 0; mcnt[k] = 0; s1[k] = 0; s2[k] = 0; ms[k] = 0;
                end else if (dv) begin
                    s1[k] = sat_add(s1[k], longint'(d1), widths[k], o1);
                    s2[k] = sat_add(s2[k], longint'(d2), widths[k], o2);
                    ms[k] = ms[k] | o1 | o2;
                    mcnt[k]++;
                    if (mcnt[k] == mlen[k]) begin
                        if (q[k].size() < 2) q[k].push_back('{a1: s1[k], a2: s2[k], s: ms[k]});
                        else movf[k] = 1;
                        mcnt[k] = 0; s1[k] = 0; s2[k] = 0; ms[k] = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) for (int k = 0; k < 2; k++) begin
            check($sformatf("vld[%0d]", k), longint'(ovld[k]), longint'(q[k].size() > 0));
            check($sformatf("ovf[%0d]", k), longint'(oovf[k]), longint'(movf[k]));
            check($sformatf("busy[%0d]", k), longint'(obusy[k]), longint'(mbusy[k]));
            if (q[k].size() > 0) begin
                check($sformatf("acc1[%0d]", k), oa1[k], q[k][0].a1);
                check($sformatf("acc2[%0d]", k), oa2[k], q[k][0].a2);
                check($sformatf("sat[%0d]", k), longint'(osat[k]), longint'(q[k][0].s));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit s, bit a, int l, bit v, int x, int y);
        start = s; abort = a; len = 16'(l); dv = v; d1 = 16'(x); d2 = 16'(y);
        cyc();
        start = 0; abort = 0; dv = 0;
    endtask

    initial begin
        cyc(); cyc();
        check("rst_vld", longint'(vld_32), 0);
        check("rst_acc1", longint'(a1_32), 0);
        check("rst_sat", longint'(sat_32), 0);
        check("rst_ovf", longint'(ovf_32), 0);
        check("rst_busy", longint'(busy_32), 0);
        rst_n = 1;
        cyc();
        // T1
        rdy = 1;
        drive(1, 0, 4, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) check("t1_latency", longint'(vld_32), 0);
            drive(0, 0, 0, 1, i, -i);
        end
        check("t1_vld", longint'(vld_32), 1);
        check("t1_acc1", longint'(a1_32), 10);
        check("t1_acc2", longint'(a2_32), -10);
        check("t1_sat", longint'(sat_32), 0);
        cyc();
        check("t1_drained", longint'(vld_32), 0);
        // T2: back-to-back windows of 3
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 3, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 0, 1, 100, 100);
            if (i == 3 || i == 6) begin
                check("t2_vld", longint'(vld_32), 1);
                check("t2_acc1", longint'(a1_32), 300);
                check("t2_acc2", longint'(a2_32), 300);
            end
        end
        // T3: 17-bit instance clamps at 65535
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 5, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 16129, 0);
        check("t3_acc1_17", longint'(a1_17), 65535);
        check("t3_sat_17", longint'(sat_17), 1);
        check("t3_acc1_32", longint'(a1_32), 80645);
        check("t3_sat_32", longint'(sat_32), 0);
        // T4: FIFO full, third result dropped
        drive(0, 1, 0, 0, 0, 0);
        rdy = 0;
        drive(1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) drive(0, 0, 0, 1, i, i);
        check("t4_head", longint'(a1_32), 1);
        check("t4_ovf", longint'(ovf_32), 1);
        rdy = 1;
        cyc();
        check("t4_second", longint'(a1_32), 2);
        check("t4_vld2", longint'(vld_32), 1);
        cyc();
        check("t4_empty", longint'(vld_32), 0);
        check("t4_ovf_sticky", longint'(ovf_32), 1);
        // T5: abort discards the partial window
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 5, 0, 0, 0);
        check("t5_ovf_clr", longint'(ovf_32), 0);
        drive(0, 0, 0, 1, 9, 9);
        drive(0, 0, 0, 1, 9, 9);
        drive(0, 1, 0, 1, 50, 50);
        check("t5_busy", longint'(busy_32), 0);
        check("t5_vld", longint'(vld_32), 0);
        drive(1, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 7, 7);
        check("t5_acc1", longint'(a1_32), 7);
        check("t5_acc2", longint'(a2_32), 7);
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 5, 6);
        check("len0_acc1", longint'(a1_32), 5);
        check("len0_acc2", longint'(a2_32), 6);
        // T6: asynchronous reset with queued results and ovf set
        drive(0, 1, 0, 0, 0, 0);
        rdy = 0;
        drive(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 3, 3);
        #2 rst_n = 0;
        #1;
        check("t6_vld", longint'(vld_32), 0);
        check("t6_ovf", longint'(ovf_32), 0);
        check("t6_busy", longint'(busy_32), 0);
        check("t6_acc1", longint'(a1_32), 0);
        cyc();
        rst_n = 1;
        cyc();
        check("t6_idle", longint'(busy_32), 0);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            rdy = $urandom % 3 != 0;
            drive($urandom % 8 == 0, $urandom % 40 == 0, int'($urandom % 5), $urandom % 4 != 0,
                  int'($urandom), int'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
